// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM port arbiter and its per-CPU hit buffers.
package rom_arb_pkg;

  localparam int MEM_AW = 23;

  typedef enum logic [1:0] {
    OWN_DL   = 2'd0,
    OWN_CPU1 = 2'd1,
    OWN_CPU2 = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  // Word address of a CPU fetch; the 23-bit sum wraps naturally.
  function automatic logic [MEM_AW-1:0] rom_word_addr(input logic [MEM_AW-1:0] base,
                                                      input logic [14:0]       word_idx);
    return base + {8'd0, word_idx};
  endfunction

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/rom_hit_buffer.sv
// One-word fetch buffer for a CPU ROM port: tag/data/valid, hit compare and byte select.
module rom_hit_buffer
  import rom_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inval_i,
  input  logic        load_i,
  input  logic [14:0] load_tag_i,
  input  logic [15:0] load_data_i,
  input  logic        hold_off_i,
  input  logic        cs_i,
  input  logic [15:0] addr_i,
  output logic        hit_o,
  output logic [7:0]  q_o
);

  logic [14:0] tag_q, tag_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Next-state: invalidation beats a coincident load; a word landing mid-download stays invalid.
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (inval_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      tag_d   = load_tag_i;
      data_d  = load_data_i;
      valid_d = ~hold_off_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q   <= 15'd0;
      data_q  <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit_o = cs_i & valid_q & (tag_q == addr_i[15:1]) & ~hold_off_i;
  assign q_o   = byte_sel(data_q, addr_i[0]);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between ROM download writes and two CPU ROM fetch ports.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [MEM_AW-1:0] CPU1_BASE = 23'h000000,
  parameter logic [MEM_AW-1:0] CPU2_BASE = 23'h008000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_overrun,
  input  logic              cpu1_cs,
  input  logic [15:0]       cpu1_addr,
  output logic [7:0]        cpu1_q,
  output logic              cpu1_valid,
  input  logic              cpu2_cs,
  input  logic [15:0]       cpu2_addr,
  output logic [7:0]        cpu2_q,
  output logic              cpu2_valid,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [MEM_AW-1:0] mem_a,
  output logic [1:0]        mem_ds,
  output logic              mem_we,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [14:0]       req_tag_q, req_tag_d;
  logic              rr_cpu2_q, rr_cpu2_d;
  logic              mem_req_q, mem_req_d;
  logic [MEM_AW-1:0] mem_a_q, mem_a_d;
  logic [1:0]        mem_ds_q, mem_ds_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_d_q, mem_d_d;
  logic              pend_valid_q, pend_valid_d;
  logic [23:0]       pend_addr_q, pend_addr_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              overrun_q, overrun_d;
  logic              dl_wr_q;
  logic              dl_active_q;

  logic dl_rise_s, wr_edge_s, ack_match_s, take_slot_s;
  logic hit1_s, hit2_s, miss1_s, miss2_s, pick_cpu2_s;
  logic load1_s, load2_s;
  logic dl_addr_unused_s;

  assign dl_addr_unused_s = dl_addr[24];

  assign dl_rise_s   = dl_active & ~dl_active_q;
  assign wr_edge_s   = dl_wr & ~dl_wr_q & dl_active;
  assign ack_match_s = (mem_ack == mem_req_q);
  assign miss1_s     = cpu1_cs & ~hit1_s;
  assign miss2_s     = cpu2_cs & ~hit2_s;
  // rr_cpu2_q only decides contention; a lone miss never moves it.
  assign pick_cpu2_s = miss2_s & (~miss1_s | rr_cpu2_q);
  assign load1_s     = (state_q == WAIT_ACK) & ack_match_s & (owner_q == OWN_CPU1);
  assign load2_s     = (state_q == WAIT_ACK) & ack_match_s & (owner_q == OWN_CPU2);

  rom_hit_buffer u_buf1 (
    .clk_i       (clk_sys),
    .reset_i     (reset),
    .inval_i     (dl_rise_s),
    .load_i      (load1_s),
    .load_tag_i  (req_tag_q),
    .load_data_i (mem_q),
    .hold_off_i  (dl_active),
    .cs_i        (cpu1_cs),
    .addr_i      (cpu1_addr),
    .hit_o       (hit1_s),
    .q_o         (cpu1_q)
  );

  rom_hit_buffer u_buf2 (
    .clk_i       (clk_sys),
    .reset_i     (reset),
    .inval_i     (dl_rise_s),
    .load_i      (load2_s),
    .load_tag_i  (req_tag_q),
    .load_data_i (mem_q),
    .hold_off_i  (dl_active),
    .cs_i        (cpu2_cs),
    .addr_i      (cpu2_addr),
    .hit_o       (hit2_s),
    .q_o         (cpu2_q)
  );

  // Transaction FSM: a pending download byte always wins over CPU misses.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_tag_d   = req_tag_q;
    rr_cpu2_d   = rr_cpu2_q;
    mem_req_d   = mem_req_q;
    mem_a_d     = mem_a_q;
    mem_ds_d    = mem_ds_q;
    mem_we_d    = mem_we_q;
    mem_d_d     = mem_d_q;
    take_slot_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          mem_a_d     = pend_addr_q[23:1];
          mem_ds_d    = {pend_addr_q[0], ~pend_addr_q[0]};
          mem_d_d     = {pend_data_q, pend_data_q};
          mem_we_d    = 1'b1;
          mem_req_d   = ~mem_req_q;
          owner_d     = OWN_DL;
          take_slot_s = 1'b1;
          state_d     = WAIT_ACK;
        end else if (!dl_active && (miss1_s || miss2_s)) begin
          if (pick_cpu2_s) begin
            mem_a_d   = rom_word_addr(CPU2_BASE, cpu2_addr[15:1]);
            req_tag_d = cpu2_addr[15:1];
            owner_d   = OWN_CPU2;
          end else begin
            mem_a_d   = rom_word_addr(CPU1_BASE, cpu1_addr[15:1]);
            req_tag_d = cpu1_addr[15:1];
            owner_d   = OWN_CPU1;
          end
          if (miss1_s && miss2_s) begin
            rr_cpu2_d = ~pick_cpu2_s;
          end else begin
            rr_cpu2_d = rr_cpu2_q;
          end
          mem_ds_d  = 2'b11;
          mem_we_d  = 1'b0;
          mem_req_d = ~mem_req_q;
          state_d   = WAIT_ACK;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack_match_s) begin
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Download slot: one byte deep; an edge that finds it occupied is dropped and flagged.
  always_comb begin
    pend_valid_d = pend_valid_q & ~take_slot_s;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (dl_rise_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (wr_edge_s) begin
      if (pend_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_addr_d  = dl_addr[23:0];
        pend_data_d  = dl_data;
      end
    end else begin
      pend_valid_d = pend_valid_q & ~take_slot_s;
    end
  end

  // State registers; reset aligns mem_req with mem_ack, abandoning any transaction in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DL;
      req_tag_q    <= 15'd0;
      rr_cpu2_q    <= 1'b0;
      mem_req_q    <= mem_ack;
      mem_a_q      <= 23'd0;
      mem_ds_q     <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_d_q      <= 16'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 24'd0;
      pend_data_q  <= 8'd0;
      overrun_q    <= 1'b0;
      dl_wr_q      <= 1'b0;
      dl_active_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      req_tag_q    <= req_tag_d;
      rr_cpu2_q    <= rr_cpu2_d;
      mem_req_q    <= mem_req_d;
      mem_a_q      <= mem_a_d;
      mem_ds_q     <= mem_ds_d;
      mem_we_q     <= mem_we_d;
      mem_d_q      <= mem_d_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
      dl_wr_q      <= dl_wr;
      dl_active_q  <= dl_active;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_a      = mem_a_q;
  assign mem_ds     = mem_ds_q;
  assign mem_we     = mem_we_q;
  assign mem_d      = mem_d_q;
  assign dl_overrun = overrun_q;
  assign cpu1_valid = hit1_s;
  assign cpu2_valid = hit2_s;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed-plus-random bench for rom_port_arbiter with an SDRAM responder and buffer model.
module tb_rom_port_arbiter;

  localparam logic [22:0] B1 = 23'h000000;
  localparam logic [22:0] B2 = 23'h008000;

  logic        clk_sys = 1'b0;
  logic        reset, dl_active, dl_wr, dl_overrun;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu1_cs, cpu1_valid, cpu2_cs, cpu2_valid;
  logic [15:0] cpu1_addr, cpu2_addr;
  logic [7:0]  cpu1_q, cpu2_q;
  logic        mem_req, mem_ack, mem_we;
  logic [22:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d, mem_q;

  always #5 clk_sys = ~clk_sys;

  rom_port_arbiter #(.CPU1_BASE(B1), .CPU2_BASE(B2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_overrun(dl_overrun),
    .cpu1_cs(cpu1_cs), .cpu1_addr(cpu1_addr), .cpu1_q(cpu1_q), .cpu1_valid(cpu1_valid),
    .cpu2_cs(cpu2_cs), .cpu2_addr(cpu2_addr), .cpu2_q(cpu2_q), .cpu2_valid(cpu2_valid),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic        ack_v;
  logic [15:0] mem_m [int];
  logic        bval [2];
  logic [14:0] btag [2];
  logic [15:0] bdat [2];

  function automatic logic [15:0] word_at(input logic [22:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return 16'hC3A5 ^ a[15:0] ^ {9'd0, a[22:16]};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected hit/byte come from the bench's own record of what each CPU has loaded.
  task automatic chk_cpu(input int n, input string tag);
    logic        cs, v, ev;
    logic [15:0] a;
    logic [7:0]  q;
    if (n == 0) begin cs = cpu1_cs; a = cpu1_addr; v = cpu1_valid; q = cpu1_q; end
    else        begin cs = cpu2_cs; a = cpu2_addr; v = cpu2_valid; q = cpu2_q; end
    ev = cs && bval[n] && (btag[n] == a[15:1]) && !dl_active;
    chk({tag, "_valid"}, v, ev);
    if (ev) chk({tag, "_q"}, q, a[0] ? bdat[n][15:8] : bdat[n][7:0]);
  endtask

  task automatic wait_pending(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mem_req !== ack_v) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++;
    assert (ok) else begin
      n_err++;
      $error("FAIL %s observed=no_request expected=request", tag);
    end
  endtask

  task automatic give_ack(input logic [15:0] q);
    mem_q   = q;
    ack_v   = ~ack_v;
    mem_ack = ack_v;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bval[0] = 1'b0;
    bval[1] = 1'b0;
  endtask

  task automatic set_cpu(input int n, input logic cs, input logic [15:0] a);
    if (n == 0) begin cpu1_cs = cs; cpu1_addr = a; end
    else        begin cpu2_cs = cs; cpu2_addr = a; end
    #1;
  endtask

  task automatic read_issue(input int n, input logic [15:0] a, input string tag, output bit ok);
    logic [22:0] ea;
    ea = ((n == 0) ? B1 : B2) + {8'd0, a[15:1]};
    wait_pending({tag, "_issue"}, ok);
    if (ok) begin
      chk({tag, "_mem_a"}, mem_a, ea);
      chk({tag, "_mem_ds"}, mem_ds, 2'b11);
      chk({tag, "_mem_we"}, mem_we, 1'b0);
    end
  endtask

  task automatic serve_read(input int n, input logic [15:0] a, input string tag);
    bit          ok;
    logic [15:0] w;
    read_issue(n, a, tag, ok);
    if (ok) begin
      repeat ($urandom_range(0, 2)) begin
        chk_cpu(n, {tag, "_wait"});
        tick();
      end
      w = word_at(((n == 0) ? B1 : B2) + {8'd0, a[15:1]});
      give_ack(w);
      bval[n] = 1'b1;
      btag[n] = a[15:1];
      bdat[n] = w;
      chk_cpu(n, {tag, "_load"});
    end
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input int hold);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    repeat (hold) tick();
    dl_wr = 1'b0;
    tick();
  endtask

  task automatic write_issue(input logic [24:0] a, input logic [7:0] d, input string tag);
    bit          ok;
    logic [15:0] w;
    wait_pending({tag, "_issue"}, ok);
    if (ok) begin
      chk({tag, "_mem_a"}, mem_a, a[23:1]);
      chk({tag, "_mem_ds"}, mem_ds, {a[0], ~a[0]});
      chk({tag, "_mem_d"}, mem_d, {d, d});
      chk({tag, "_mem_we"}, mem_we, 1'b1);
    end
    w = word_at(a[23:1]);
    if (a[0]) w[15:8] = d; else w[7:0] = d;
    mem_m[int'(a[23:1])] = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit          ok, hit;
    int          n;
    logic [15:0] a;
    logic [24:0] ra, rb, rc;
    logic [7:0]  da, db, dc;

    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 8'd0;
    cpu1_cs = 1'b0; cpu1_addr = 16'd0; cpu2_cs = 1'b0; cpu2_addr = 16'd0;
    ack_v = 1'b1; mem_ack = 1'b1; mem_q = 16'd0;
    tick();
    tick();
    do_reset();
    chk("rst_mem_req", mem_req, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_ds", mem_ds, 2'b00);
    chk("rst_mem_a", mem_a, 23'd0);
    chk("rst_mem_d", mem_d, 16'd0);
    chk("rst_overrun", dl_overrun, 1'b0);
    tick();
    chk("rst_no_req", mem_req, ack_v);

    // First cpu1 fetch, both bytes of the word.
    set_cpu(0, 1'b1, 16'h0005);
    chk("c1_cold_valid", cpu1_valid, 1'b0);
    read_issue(0, 16'h0005, "c1_first", ok);
    chk("c1_first_req_toggled", mem_req, 1'b0);
    mem_m[2] = 16'hBEEF;
    give_ack(16'hBEEF);
    bval[0] = 1'b1; btag[0] = 15'd2; bdat[0] = 16'hBEEF;
    chk("c1_hit_valid", cpu1_valid, 1'b1);
    chk("c1_hit_q_hi", cpu1_q, 8'hBE);
    set_cpu(0, 1'b1, 16'h0004);
    chk("c1_hit_q_lo", cpu1_q, 8'hEF);
    tick();
    chk("c1_hit_no_req", mem_req, ack_v);
    chk_cpu(0, "c1_hit_after");

    // Simultaneous misses alternate between the CPUs.
    cpu1_addr = 16'h0010; cpu2_cs = 1'b1; cpu2_addr = 16'h0020;
    #1;
    serve_read(0, 16'h0010, "rr1_cpu1");
    chk_cpu(1, "rr1_cpu2_pending");
    serve_read(1, 16'h0020, "rr1_cpu2");
    chk_cpu(0, "rr1_cpu1_kept");
    cpu1_addr = 16'h0030; cpu2_addr = 16'h0040;
    #1;
    serve_read(1, 16'h0040, "rr2_cpu2");
    serve_read(0, 16'h0030, "rr2_cpu1");

    // Random single-CPU fetches, biased toward re-hitting the buffered word.
    cpu1_cs = 1'b0; cpu2_cs = 1'b0;
    for (int i = 0; i < 24; i++) begin
      n = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0 && bval[n]) a = {btag[n], 1'($urandom_range(0, 1))};
      else a = 16'($urandom);
      hit = bval[n] && (btag[n] == a[15:1]);
      set_cpu(1 - n, 1'b0, 16'd0);
      set_cpu(n, 1'b1, a);
      chk_cpu(n, "rnd_pre");
      if (hit) begin
        tick();
        chk("rnd_hit_no_req", mem_req, ack_v);
        chk_cpu(n, "rnd_hit");
      end else begin
        serve_read(n, a, "rnd_miss");
      end
    end

    // Download: writes go through, CPU fetches are held off, tags drop on the rising edge.
    cpu1_cs = 1'b1; cpu2_cs = 1'b1;
    dl_active = 1'b1;
    bval[0] = 1'b0; bval[1] = 1'b0;
    tick();
    chk_cpu(0, "dl_c1_held");
    chk_cpu(1, "dl_c2_held");
    dl_byte(25'h0000003, 8'h12, 1);
    write_issue(25'h0000003, 8'h12, "dl_w1");
    chk_cpu(0, "dl_w1_c1");
    give_ack(16'h0000);
    dl_byte(25'h0000004, 8'h34, 3);
    write_issue(25'h0000004, 8'h34, "dl_w2");
    give_ack(16'h0000);
    for (int i = 0; i < 3; i++) begin
      ra = 25'($urandom_range(0, 32'h1FFFF));
      da = 8'($urandom);
      dl_byte(ra, da, int'($urandom_range(1, 3)));
      write_issue(ra, da, "dl_rnd");
      give_ack(16'h0000);
    end
    tick();
    chk("dl_no_cpu_req", mem_req, ack_v);
    chk_cpu(1, "dl_c2_end");

    // Overrun: second byte lands in the slot, third is lost.
    cpu1_cs = 1'b0; cpu2_cs = 1'b0;
    ra = 25'h0000100; rb = 25'h0000205; rc = 25'h0000300;
    da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom);
    dl_byte(ra, da, 1);
    write_issue(ra, da, "ovr_a");
    dl_byte(rb, db, 1);
    chk("ovr_not_yet", dl_overrun, 1'b0);
    dl_byte(rc, dc, 2);
    chk("ovr_set", dl_overrun, 1'b1);
    give_ack(16'h0000);
    write_issue(rb, db, "ovr_b");
    give_ack(16'h0000);
    repeat (3) tick();
    chk("ovr_c_dropped", mem_req, ack_v);
    dl_active = 1'b0;
    tick();
    chk("ovr_sticky", dl_overrun, 1'b1);
    dl_active = 1'b1;
    tick();
    chk("ovr_cleared", dl_overrun, 1'b0);
    dl_active = 1'b0;
    tick();
    set_cpu(0, 1'b1, 16'h0004);
    chk("post_dl_tag_invalid", cpu1_valid, 1'b0);
    serve_read(0, 16'h0004, "post_dl_read");

    // Reset while a read is outstanding, then a clean cpu2 fetch.
    set_cpu(0, 1'b1, 16'h1234);
    read_issue(0, 16'h1234, "abandon", ok);
    cpu1_cs = 1'b0;
    do_reset();
    chk("abandon_req_eq_ack", mem_req, ack_v);
    chk("abandon_we", mem_we, 1'b0);
    tick();
    chk("abandon_idle", mem_req, ack_v);
    set_cpu(1, 1'b1, 16'h00AB);
    chk_cpu(1, "after_rst_c2");
    serve_read(1, 16'h00AB, "after_rst_c2");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one toggle-handshake SDRAM port between three requesters: ROM download writes, main CPU (cpu1) ROM fetches and sound CPU (cpu2) ROM fetches.
- Sits between the data_io download stream, the core's CPU ROM buses and the sdram port1 interface.
- Each CPU gets a one-word (16-bit) hit buffer, so sequential byte fetches cost one SDRAM access per word.

Parameters:
- CPU1_BASE, 23'h000000, word base address of cpu1 ROM in SDRAM.
- CPU2_BASE, 23'h008000, word base address of cpu2 ROM in SDRAM.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- dl_active  in  1  ROM download in progress.
- dl_wr  in  1  download byte strobe (level; may last several clocks).
- dl_addr  in  25  download byte address.
- dl_data  in  8  download byte.
- dl_overrun  out  1  sticky: a download byte was lost.
- cpu1_cs  in  1  cpu1 fetch request (level).
- cpu1_addr  in  16  cpu1 byte address.
- cpu1_q  out  8  cpu1 fetched byte.
- cpu1_valid  out  1  cpu1_q valid for current cpu1_addr.
- cpu2_cs, cpu2_addr, cpu2_q, cpu2_valid: same as cpu1.
- mem_req  out  1  toggle request.
- mem_ack  in  1  toggle acknowledge; the transaction is complete when mem_ack == mem_req.
- mem_a  out  23  word address.
- mem_ds  out  2  byte enables {hi, lo}.
- mem_we  out  1  write transaction.
- mem_d  out  16  write data.
- mem_q  in  16  read data, valid when the ack matches.

Behaviour:
- Reset:
  - mem_req <= mem_ack (no transaction pending).
  - mem_we = 0, mem_ds = 2'b00, mem_a = 0, mem_d = 0.
  - State IDLE; both buffer tags invalid; pending write cleared; dl_overrun = 0.
  - A reset during WAIT_ACK abandons the transaction without waiting for the ack.
- Download capture:
  - A rising edge of dl_wr while dl_active latches dl_addr and dl_data into a one-entry pending slot.
  - An edge arriving while the slot is still full sets dl_overrun; the new byte is dropped.
  - dl_overrun clears only on reset or on a dl_active rising edge.
- Hit buffers:
  - Each CPU has a tag (addr[15:1]), a 16-bit data word and a tag-valid bit.
  - cpuN_valid = cpuN_cs & tag_valid & (tag == cpuN_addr[15:1]) & ~dl_active. This is combinational from registered state, so a hit has 0-cycle latency.
  - cpuN_q = addr[0] ? data[15:8] : data[7:0].
  - Both tags are invalidated on the dl_active rising edge.
  - cpuN_q is don't-care whenever cpuN_valid = 0.
- State machine (two states):
  - IDLE, issue priority 1, download write: if the pending slot is full, then:
    - mem_a = dl_addr[23:1], mem_ds = {dl_addr[0], ~dl_addr[0]}, mem_d = {dl_data, dl_data}, mem_we = 1.
    - Toggle mem_req, clear the slot, go to WAIT_ACK.
  - IDLE, issue priority 2, CPU miss (only when ~dl_active): a CPU misses when cs is high and its buffer does not hit.
    - If both miss, round-robin: serve the CPU not served last; after reset cpu1 goes first.
    - mem_a = CPUn_BASE + addr[15:1], mem_ds = 2'b11, mem_we = 0.
    - Toggle mem_req; record the owner and the requested tag; go to WAIT_ACK.
  - WAIT_ACK: when mem_ack == mem_req:
    - For a read, load the owner's data from mem_q, set the tag to the recorded tag, set tag_valid.
    - Deassert mem_we and go to IDLE. No issue happens in the same cycle.
  - Minimum miss-to-valid latency: 1 cycle to issue + SDRAM ack time + 1 cycle to load.
- Address changes and drops:
  - If a CPU changes its address during WAIT_ACK, the old word is still loaded. It is then a miss for the new address and is re-requested in the next IDLE.
  - If cs drops during WAIT_ACK, the word is still loaded.
- Address arithmetic: CPUn_BASE + addr[15:1] is computed at 23 bits and wraps modulo 2^23.
- Writes are never lost while dl_active is high; CPU misses are held off.

Decomposition:
- Shared package rom_arb_pkg:
  - owner_e {OWN_DL, OWN_CPU1, OWN_CPU2}.
  - state_e {IDLE, WAIT_ACK}.
  - Address width constant MEM_AW = 23.
- One sub-module, rom_hit_buffer, instantiated twice. It holds tag/data/valid, hit compare, byte select, load and invalidate.

Test Plan:
- Reset with mem_ack = 1 → mem_req = 1 and no transaction. Then cpu1_cs = 1, cpu1_addr = 16'h0005 → mem_a = 23'h000002, mem_ds = 11, mem_we = 0, req toggles. Ack with mem_q = 16'hBEEF → next cycle cpu1_valid = 1, cpu1_q = 8'hBE. Change cpu1_addr to 16'h0004 → cpu1_q = 8'hEF in the same cycle, no new request.
- Both CPUs miss in the same cycle (cpu1 0x0010, cpu2 0x0020) → cpu1 is served first at mem_a 23'h000008, then cpu2 at 23'h008010. On a second simultaneous miss, cpu2 goes first.
- Download: dl_active = 1, bytes 8'h12 @ 25'h000003 and 8'h34 @ 25'h000004 with acks → writes at mem_a = 1, ds = 10, d = 16'h1212, then mem_a = 2, ds = 01, d = 16'h3434. CPU valids stay 0 throughout; tags are invalid after the dl_active edge.
- Hold the ack off while two dl_wr edges arrive → the second byte is dropped and dl_overrun = 1. dl_overrun persists until the next dl_active rise.
- Assert reset during WAIT_ACK → state IDLE and mem_req equals mem_ack the next cycle. A later cpu2 miss issues normally with valid 0 until its ack.
